// File: rtl/i2c_pkg.sv
// Shared I2C slave constants: channel indices and line-filter defaults.
// Latency: n/a (compile-time constants and helpers only).
// Backpressure: n/a.
package i2c_pkg;

  // Channel indices on the multi-line conditioner
  localparam int I2C_SCL = 0;
  localparam int I2C_SDA = 1;
  localparam int I2C_CHANNELS = 2;

  // Defaults shared by the slave top and the line filter so both agree
  localparam int I2C_SYNC_STAGES = 2;
  localparam int I2C_FILTER_LEN  = 4;

  // Width of a counter that must reach len-1; never narrower than one bit
  function automatic int cnt_width(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/i2c_sync_chain.sv
// Single-bit multi-flop synchroniser with a synchronous reset value.
// Latency: STAGES cycles from d_i capture to q_o.
// Backpressure: none; samples every cycle.
module i2c_sync_chain
  import i2c_pkg::*;
#(
  parameter int   STAGES  = I2C_SYNC_STAGES,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the raw sample one stage deeper each cycle
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  // Synchroniser flops; reset to the idle bus level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_line_filter.sv
// Multi-channel I2C line conditioner: synchronise, deglitch, edge-detect.
// Latency: SYNC_STAGES + FILTER_LEN cycles inp->level/pos/neg; any_edge one more.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int                  CHANNELS    = I2C_CHANNELS,
  parameter int                  SYNC_STAGES = I2C_SYNC_STAGES,
  parameter int                  FILTER_LEN  = I2C_FILTER_LEN,
  parameter logic [CHANNELS-1:0] RST_VAL     = {CHANNELS{1'b1}}
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [CHANNELS-1:0] inp,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pos,
  output logic [CHANNELS-1:0] neg,
  output logic                any_edge
);

  localparam int               CNT_W   = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

  logic [CHANNELS-1:0] edge_vec;
  logic                any_edge_q;
  logic                any_edge_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic             s;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             pos_q;
    logic             pos_d;
    logic             neg_q;
    logic             neg_d;

    i2c_sync_chain #(
      .STAGES  (SYNC_STAGES),
      .RST_VAL (RST_VAL[c])
    ) u_sync (
      .clk_i (sys_clk),
      .rst_i (sys_rst),
      .d_i   (inp[c]),
      .q_o   (s)
    );

    // Stability counter: a new level is accepted only after it has held
    // for FILTER_LEN consecutive cycles; any return to the old level
    // throws the partial count away.
    always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      pos_d   = 1'b0;
      neg_d   = 1'b0;
      if (s == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        level_d = s;
        cnt_d   = '0;
        pos_d   = s;
        neg_d   = ~s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Per-channel filter state and registered edge pulses
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        cnt_q   <= '0;
        level_q <= RST_VAL[c];
        pos_q   <= 1'b0;
        neg_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        pos_q   <= pos_d;
        neg_q   <= neg_d;
      end
    end

    assign level[c]    = level_q;
    assign pos[c]      = pos_q;
    assign neg[c]      = neg_q;
    assign edge_vec[c] = pos_q | neg_q;

    a_pos_neg_excl : assert property (@(posedge sys_clk) !(pos_q && neg_q));
    a_cnt_bound    : assert property (@(posedge sys_clk) cnt_q <= CNT_MAX);
  end : g_ch

  // Summary flag is built from the registered pulses, so it trails them by one
  always_comb begin
    any_edge_d = |edge_vec;
  end

  // Registered any-edge flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= any_edge_d;
    end
  end

  assign any_edge = any_edge_q;

endmodule

// File: tb/tb_i2c_line_filter.sv
module tb_i2c_line_filter;

  logic       clk;
  logic       rst;
  logic [1:0] inp;

  logic [1:0] level0, pos0, neg0;
  logic       any0;
  logic [1:0] level1, pos1, neg1;
  logic       any1;

  int checks = 0;
  int errors = 0;

  i2c_line_filter #(
    .CHANNELS(2), .SYNC_STAGES(2), .FILTER_LEN(4), .RST_VAL(2'b11)
  ) dut0 (
    .sys_clk(clk), .sys_rst(rst), .inp(inp),
    .level(level0), .pos(pos0), .neg(neg0), .any_edge(any0)
  );

  i2c_line_filter #(
    .CHANNELS(2), .SYNC_STAGES(3), .FILTER_LEN(1), .RST_VAL(2'b11)
  ) dut1 (
    .sys_clk(clk), .sys_rst(rst), .inp(inp),
    .level(level1), .pos(pos1), .neg(neg1), .any_edge(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Model of each instance: the line seen by the filter is inp delayed by
  // the synchroniser depth; a channel's level flips once the delayed line
  // has disagreed with it for FILTER_LEN edges in a row.
  logic [1:0] m_dl  [2][4];
  int         m_run [2][2];
  logic [1:0] m_lvl [2];
  logic [1:0] m_pos [2];
  logic [1:0] m_neg [2];
  logic       m_any [2];

  function automatic int depth_of(input int id);
    return (id == 0) ? 2 : 3;
  endfunction

  function automatic int flen_of(input int id);
    return (id == 0) ? 4 : 1;
  endfunction

  task automatic model_step(input int id, input logic r, input logic [1:0] v);
    int         sy;
    int         fl;
    logic [1:0] s_old;
    logic [1:0] np;
    logic [1:0] nn;
    sy = depth_of(id);
    fl = flen_of(id);
    if (r) begin
      for (int i = 0; i < 4; i++) m_dl[id][i] = 2'b11;
      m_lvl[id] = 2'b11;
      m_pos[id] = 2'b00;
      m_neg[id] = 2'b00;
      m_any[id] = 1'b0;
      for (int c = 0; c < 2; c++) m_run[id][c] = 0;
    end else begin
      s_old = m_dl[id][sy-1];
      m_any[id] = |(m_pos[id] | m_neg[id]);
      np = 2'b00;
      nn = 2'b00;
      for (int c = 0; c < 2; c++) begin
        if (s_old[c] != m_lvl[id][c]) begin
          m_run[id][c] = m_run[id][c] + 1;
          if (m_run[id][c] >= fl) begin
            m_lvl[id][c] = s_old[c];
            np[c] = s_old[c];
            nn[c] = ~s_old[c];
            m_run[id][c] = 0;
          end
        end else begin
          m_run[id][c] = 0;
        end
      end
      m_pos[id] = np;
      m_neg[id] = nn;
      for (int i = sy - 1; i > 0; i--) m_dl[id][i] = m_dl[id][i-1];
      m_dl[id][0] = v;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got {lvl,pos,neg,any}=%b want=%b", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [1:0] v);
    rst = r;
    inp = v;
    @(posedge clk);
    model_step(0, r, v);
    model_step(1, r, v);
    #1;
  endtask

  task automatic chk_models(input string tag);
    chk({tag, "_m0"}, {level0, pos0, neg0, any0}, {m_lvl[0], m_pos[0], m_neg[0], m_any[0]});
    chk({tag, "_m1"}, {level1, pos1, neg1, any1}, {m_lvl[1], m_pos[1], m_neg[1], m_any[1]});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string      name;
    logic       r;
    logic [1:0] v;
    int         n;
    logic [1:0] lvl;
    logic [1:0] p;
    logic [1:0] ng;
    logic       any;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic r, input logic [1:0] v, input int n,
                              input logic [1:0] lvl, input logic [1:0] p,
                              input logic [1:0] ng, input logic any);
    vec_t t;
    t.name = nm; t.r = r; t.v = v; t.n = n;
    t.lvl = lvl; t.p = p; t.ng = ng; t.any = any;
    return t;
  endfunction

  logic [1:0] sw_in [6];
  logic [1:0] sw_l  [6];
  logic [1:0] sw_p  [6];
  logic [1:0] sw_n  [6];
  logic       sw_a  [6];
  logic [1:0] rv;

  initial begin
    rst = 1'b1;
    inp = 2'b00;

    // reset with lines low, then the release-induced fall on both lines
    tbl.push_back(mk("rst_hold",   1, 2'b00, 3, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("rel_wait",   0, 2'b00, 5, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("rel_neg",    0, 2'b00, 1, 2'b00, 2'b00, 2'b11, 0));
    tbl.push_back(mk("rel_any",    0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1));
    tbl.push_back(mk("rel_quiet",  0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 0));
    // both rise together
    tbl.push_back(mk("both_up_w",  0, 2'b11, 5, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk("both_pos",   0, 2'b11, 1, 2'b11, 2'b11, 2'b00, 0));
    tbl.push_back(mk("both_up_a",  0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 1));
    tbl.push_back(mk("both_up_q",  0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0));
    // clean fall on channel 0 only
    tbl.push_back(mk("ch0_dn_w",   0, 2'b10, 5, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("ch0_neg",    0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 0));
    tbl.push_back(mk("ch0_dn_a",   0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 1));
    tbl.push_back(mk("ch0_dn_q",   0, 2'b10, 2, 2'b10, 2'b00, 2'b00, 0));
    tbl.push_back(mk("ch0_up_w",   0, 2'b11, 5, 2'b10, 2'b00, 2'b00, 0));
    tbl.push_back(mk("ch0_pos",    0, 2'b11, 1, 2'b11, 2'b01, 2'b00, 0));
    tbl.push_back(mk("ch0_up_a",   0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 1));
    tbl.push_back(mk("ch0_up_q",   0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0));
    // 3-cycle glitch on SDA is rejected
    tbl.push_back(mk("glitch3",    0, 2'b01, 3, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("glitch3_q",  0, 2'b11, 6, 2'b11, 2'b00, 2'b00, 0));
    // 4-cycle low on SDA is accepted, as is the return high
    tbl.push_back(mk("low4",       0, 2'b01, 4, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("low4_w",     0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("low4_neg",   0, 2'b11, 1, 2'b01, 2'b00, 2'b10, 0));
    tbl.push_back(mk("low4_any",   0, 2'b11, 1, 2'b01, 2'b00, 2'b00, 1));
    tbl.push_back(mk("high_w",     0, 2'b11, 2, 2'b01, 2'b00, 2'b00, 0));
    tbl.push_back(mk("high_pos",   0, 2'b11, 1, 2'b11, 2'b10, 2'b00, 0));
    tbl.push_back(mk("high_any",   0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 1));
    tbl.push_back(mk("high_q",     0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0));
    // simultaneous fall and rise
    tbl.push_back(mk("sim_dn_w",   0, 2'b00, 5, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("sim_neg",    0, 2'b00, 1, 2'b00, 2'b00, 2'b11, 0));
    tbl.push_back(mk("sim_dn_a",   0, 2'b00, 1, 2'b00, 2'b00, 2'b00, 1));
    tbl.push_back(mk("sim_up_w",   0, 2'b11, 5, 2'b00, 2'b00, 2'b00, 0));
    tbl.push_back(mk("sim_pos",    0, 2'b11, 1, 2'b11, 2'b11, 2'b00, 0));
    tbl.push_back(mk("sim_up_a",   0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 1));
    tbl.push_back(mk("sim_up_q",   0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0));
    // reset while channel 0 counter sits at 2
    tbl.push_back(mk("mid_cnt",    0, 2'b10, 4, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("mid_rst",    1, 2'b10, 2, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("mid_rel_w",  0, 2'b10, 5, 2'b11, 2'b00, 2'b00, 0));
    tbl.push_back(mk("mid_neg",    0, 2'b10, 1, 2'b10, 2'b00, 2'b01, 0));
    tbl.push_back(mk("mid_any",    0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 1));
    tbl.push_back(mk("mid_q",      0, 2'b10, 2, 2'b10, 2'b00, 2'b00, 0));
    tbl.push_back(mk("fin_up_w",   0, 2'b11, 5, 2'b10, 2'b00, 2'b00, 0));
    tbl.push_back(mk("fin_pos",    0, 2'b11, 1, 2'b11, 2'b01, 2'b00, 0));
    tbl.push_back(mk("fin_any",    0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 1));
    tbl.push_back(mk("fin_q",      0, 2'b11, 2, 2'b11, 2'b00, 2'b00, 0));

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step(tbl[i].r, tbl[i].v);
        chk(tbl[i].name, {level0, pos0, neg0, any0},
            {tbl[i].lvl, tbl[i].p, tbl[i].ng, tbl[i].any});
        chk_models({tbl[i].name, "_ref"});
      end
    end

    // FILTER_LEN=1 / SYNC_STAGES=3: 1-cycle dip on SCL passes with latency 4,
    // while the default instance ignores it.
    sw_in[0] = 2'b10; sw_in[1] = 2'b11; sw_in[2] = 2'b11;
    sw_in[3] = 2'b11; sw_in[4] = 2'b11; sw_in[5] = 2'b11;
    sw_l[0] = 2'b11; sw_l[1] = 2'b11; sw_l[2] = 2'b11;
    sw_l[3] = 2'b10; sw_l[4] = 2'b11; sw_l[5] = 2'b11;
    sw_p[0] = 2'b00; sw_p[1] = 2'b00; sw_p[2] = 2'b00;
    sw_p[3] = 2'b00; sw_p[4] = 2'b01; sw_p[5] = 2'b00;
    sw_n[0] = 2'b00; sw_n[1] = 2'b00; sw_n[2] = 2'b00;
    sw_n[3] = 2'b01; sw_n[4] = 2'b00; sw_n[5] = 2'b00;
    sw_a[0] = 1'b0; sw_a[1] = 1'b0; sw_a[2] = 1'b0;
    sw_a[3] = 1'b0; sw_a[4] = 1'b1; sw_a[5] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1'b0, sw_in[k]);
      chk("sweep_fl1", {level1, pos1, neg1, any1}, {sw_l[k], sw_p[k], sw_n[k], sw_a[k]});
      chk("sweep_dflt", {level0, pos0, neg0, any0}, 7'b11_00_00_0);
    end

    // randomised lines with occasional resets against the model
    rv = 2'b11;
    for (int k = 0; k < 3000; k++) begin
      rv[0] = rv[0] ^ ($urandom_range(0, 3) == 0);
      rv[1] = rv[1] ^ ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 199) == 0, rv);
      chk_models("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
